// File: rtl/zero_iter_if.sv
// zero_iter_if: bundles the vector-in / index-out handshakes of zero_iter.
// The optional zcount signal exists only when ZERO_ITER_COUNT_EN is defined.
interface zero_iter_if #(
  parameter int N = 8,
  parameter int A = 3
);
  logic [N-1:0] seq;
  logic         in_valid;
  logic         in_ready;
  logic [A-1:0] addr;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         done;
`ifdef ZERO_ITER_COUNT_EN
  logic [A:0]   zcount;
`endif

  // Design side: consumes vectors, produces indices.
  modport slave (
    input  seq, in_valid, out_ready,
    output in_ready, addr, out_valid, out_last, done
`ifdef ZERO_ITER_COUNT_EN
    , output zcount
`endif
  );

  // Environment side: produces vectors, consumes indices.
  modport master (
    output seq, in_valid, out_ready,
    input  in_ready, addr, out_valid, out_last, done
`ifdef ZERO_ITER_COUNT_EN
    , input zcount
`endif
  );
endinterface

// File: rtl/zero_iter.sv
// zero_iter: accepts an N-bit vector and emits the index of every zero bit,
// lowest first, one per output handshake. out_last flags the final zero and
// done pulses once the vector is exhausted (or immediately for an all-ones
// vector).
// Optional feature macro: ZERO_ITER_COUNT_EN adds zcount, the number of zeros
// in the most recently accepted vector.
module zero_iter #(
  parameter int N = 8,
  parameter int A = 3
) (
  input  logic       clk,
  input  logic       rst,
  zero_iter_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_mask;
  logic [N-1:0] w_mask_next;
  logic         r_done;
  logic         w_done_next;

  logic [N-1:0] w_zero;   // 1 where a zero is still pending
  logic [N-1:0] w_low;    // one-hot of the lowest pending zero
  logic [N-1:0] w_rest;   // pending zeros other than the lowest
  logic [A-1:0] w_addr;
  logic         w_last;
  logic         w_scan;

  assign w_scan = (r_state == SCAN);
  assign w_zero = ~r_mask;
  assign w_low  = w_zero & (~w_zero + N'(1));
  assign w_rest = w_zero & (w_zero - N'(1));
  // Exactly one zero left: some zero pending, none besides the lowest.
  assign w_last = w_scan && (w_zero != '0) && (w_rest == '0);

  // Priority encoder: lowest pending zero index; 0 when the mask is all ones.
  always_comb begin
    w_addr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_zero[i]) w_addr = A'(i);
    end
  end

  // Next-state logic: accept in IDLE, retire one zero per beat in SCAN.
  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_mask_next = bus.seq;
          if (&bus.seq) begin
            // Nothing to emit: finish straight away without leaving IDLE.
            w_done_next = 1'b1;
          end else begin
            w_state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          w_mask_next = r_mask | w_low;
          if (w_last) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, mask and done registers; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      r_done  <= w_done_next;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = w_scan;
  assign bus.addr      = w_addr;
  assign bus.out_last  = w_last;
  assign bus.done      = r_done;

`ifdef ZERO_ITER_COUNT_EN
  localparam int CW = A + 1;

  logic [A:0] r_zcount;
  logic [A:0] w_seq_zeros;

  // Popcount of zeros in the incoming vector.
  always_comb begin
    w_seq_zeros = '0;
    for (int i = 0; i < N; i++) begin
      w_seq_zeros = w_seq_zeros + CW'(~bus.seq[i]);
    end
  end

  // Capture the zero count on every accepted vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zcount <= '0;
    end else if (bus.in_valid && (r_state == IDLE)) begin
      r_zcount <= w_seq_zeros;
    end
  end

  assign bus.zcount = r_zcount;
`endif

endmodule

// File: tb/tb_zero_iter.sv
// tb_zero_iter: directed and randomized checks of zero_iter (N=8, A=3)
// against a queue-of-indices reference model.
module tb_zero_iter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  zero_iter_if #(.N(8), .A(3)) zif ();

  zero_iter #(.N(8), .A(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (zif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Send one vector and follow it through to done.
  // stall: first beats held back; pct: chance of out_ready afterwards;
  // inject: pulse in_valid with inj_seq while scanning.
  task automatic run_vec(input logic [7:0] v, input int stall, input int pct,
                         input bit inject, input logic [7:0] inj_seq);
    int         exp_q[$];
    int         nz;
    int         cyc;
    int         beats;
    logic [2:0] exp_addr;
    for (int i = 0; i < 8; i++) if (!v[i]) exp_q.push_back(i);
    nz = exp_q.size();
    beats = 0;
    @(negedge clk);
    n_cmp++;
    if (zif.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pre_in_ready: got %b want 1", zif.in_ready);
    end
    zif.in_valid  = 1'b1;
    zif.seq       = v;
    zif.out_ready = 1'b0;
    @(negedge clk);
    zif.in_valid = 1'b0;
    zif.seq      = 8'($urandom);
`ifdef ZERO_ITER_COUNT_EN
    n_cmp++;
    if (int'(zif.zcount) !== nz) begin
      n_fail++; $display("FAIL zcount: got %0d want %0d", zif.zcount, nz);
    end
`endif
    if (nz == 0) begin
      n_cmp++;
      if (zif.out_valid !== 1'b0 || zif.done !== 1'b1 || zif.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL all_ones: got out_valid=%b done=%b in_ready=%b want 0 1 1",
                 zif.out_valid, zif.done, zif.in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (zif.done !== 1'b0 || zif.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse: got done=%b out_valid=%b want 0 0", zif.done, zif.out_valid);
      end
      $display("vec %b: 0 beats, done", v);
      return;
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      exp_addr = exp_q[0][2:0];
      n_cmp++;
      if (zif.out_valid !== 1'b1 || zif.in_ready !== 1'b0 || zif.done !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_flags: got out_valid=%b in_ready=%b done=%b want 1 0 0",
                 zif.out_valid, zif.in_ready, zif.done);
      end
      n_cmp++;
      if (zif.addr !== exp_addr) begin
        n_fail++; $display("FAIL addr: got %0d want %0d", zif.addr, exp_addr);
      end
      n_cmp++;
      if (zif.out_last !== (exp_q.size() == 1)) begin
        n_fail++;
        $display("FAIL out_last: got %b want %b", zif.out_last, (exp_q.size() == 1));
      end
      zif.out_ready = (cyc >= stall) && ($urandom_range(99, 0) < pct);
      if (inject) begin
        zif.in_valid = 1'($urandom_range(1, 0));
        zif.seq      = inj_seq;
      end
      if (zif.out_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end
      cyc++;
      @(negedge clk);
      zif.in_valid = 1'b0;
    end
    zif.out_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL beat_timeout: got %0d beats want %0d", beats, nz);
    end
    n_cmp++;
    if (zif.done !== 1'b1 || zif.out_valid !== 1'b0 || zif.in_ready !== 1'b1 ||
        zif.out_last !== 1'b0 || zif.addr !== 3'd0) begin
      n_fail++;
      $display("FAIL end_state: got done=%b out_valid=%b in_ready=%b last=%b addr=%0d want 1 0 1 0 0",
               zif.done, zif.out_valid, zif.in_ready, zif.out_last, zif.addr);
    end
    @(negedge clk);
    n_cmp++;
    if (zif.done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: got %b want 0", zif.done);
    end
    $display("vec %b: %0d beats in %0d cycles, done", v, beats, cyc);
  endtask

  task automatic test_reset();
    zif.in_valid  = 1'b0;
    zif.seq       = 8'h00;
    zif.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (zif.in_ready !== 1'b1 || zif.out_valid !== 1'b0 || zif.out_last !== 1'b0 ||
        zif.done !== 1'b0 || zif.addr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b last=%b done=%b addr=%0d want 1 0 0 0 0",
               zif.in_ready, zif.out_valid, zif.out_last, zif.done, zif.addr);
    end
`ifdef ZERO_ITER_COUNT_EN
    n_cmp++;
    if (zif.zcount !== 4'd0) begin
      n_fail++; $display("FAIL reset_zcount: got %0d want 0", zif.zcount);
    end
`endif
    $display("reset: done");
  endtask

  task automatic test_directed();
    run_vec(8'b00001011, 0, 100, 1'b0, 8'h00);
    run_vec(8'b11111111, 0, 100, 1'b0, 8'h00);
    run_vec(8'b00000000, 0, 100, 1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    run_vec(8'b11101111, 5, 100, 1'b0, 8'h00);
  endtask

  task automatic test_ignore_in_scan();
    run_vec(8'b01001011, 0, 100, 1'b1, 8'b00000001);
  endtask

  task automatic test_reset_midscan();
    @(negedge clk);
    zif.in_valid  = 1'b1;
    zif.seq       = 8'b00010000;
    zif.out_ready = 1'b0;
    @(negedge clk);
    zif.in_valid  = 1'b0;
    zif.out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      n_cmp++;
      if (zif.out_valid !== 1'b1 || zif.addr !== 3'(b)) begin
        n_fail++;
        $display("FAIL midscan_beat: got valid=%b addr=%0d want 1 %0d", zif.out_valid, zif.addr, b);
      end
      if (b < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    zif.out_ready = 1'b0;
    n_cmp++;
    if (zif.out_valid !== 1'b0 || zif.done !== 1'b0 || zif.in_ready !== 1'b1 ||
        zif.out_last !== 1'b0 || zif.addr !== 3'd0) begin
      n_fail++;
      $display("FAIL midscan_reset: got valid=%b done=%b in_ready=%b last=%b addr=%0d want 0 0 1 0 0",
               zif.out_valid, zif.done, zif.in_ready, zif.out_last, zif.addr);
    end
`ifdef ZERO_ITER_COUNT_EN
    n_cmp++;
    if (zif.zcount !== 4'd0) begin
      n_fail++; $display("FAIL midscan_zcount: got %0d want 0", zif.zcount);
    end
`endif
    $display("vec 00010000: reset after 2 beats");
    run_vec(8'b11111110, 0, 100, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_vec(8'($urandom), 0, int'($urandom_range(100, 30)),
              1'($urandom_range(1, 0)), 8'($urandom));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midscan();
    test_ignore_in_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
